// File: rtl/arbitro_param.sv
// N-to-N word router: arbitrates FIFO heads by round-robin or fixed priority and
// forwards each granted word to the output FIFO named in its destination field.
module arbitro_param #(
    parameter int N  = 4,
    parameter int DW = 10,
    parameter int CW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            modo,
    input  logic [N-1:0]    empty,
    input  logic [N*DW-1:0] data_poped,
    input  logic [N-1:0]    alm_full,
    output logic [N-1:0]    pop,
    output logic [N-1:0]    push,
    output logic [N*DW-1:0] data_pushed,
    output logic [N*CW-1:0] cuenta,
    output logic            idle
);

    localparam int LN = $clog2(N);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [LN-1:0]   ptr_reg;
    logic            stage_valid_reg;
    logic [DW-1:0]   stage_data_reg;
    logic [LN-1:0]   stage_dest_reg;
    logic [CW-1:0]   cnt_reg [N];

    logic [LN-1:0]   dest [N];
    logic [N-1:0]    eligible;
    logic            grant_valid;
    logic            grant_en;
    logic [LN-1:0]   grant_idx;
    logic [LN-1:0]   rr_idx;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_in
            assign dest[gi]     = data_poped[gi*DW + DW-1 -: LN];
            assign eligible[gi] = !empty[gi] && !alm_full[dest[gi]];
        end
    endgenerate

    // Descending scans so the highest-priority candidate is assigned last and wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        rr_idx      = '0;
        if (modo) begin
            for (int k = N-1; k >= 0; k--) begin
                if (eligible[k]) begin
                    grant_valid = 1'b1;
                    grant_idx   = k[LN-1:0];
                end
            end
        end else begin
            for (int k = N; k >= 1; k--) begin
                rr_idx = ptr_reg + k[LN-1:0];
                if (eligible[rr_idx]) begin
                    grant_valid = 1'b1;
                    grant_idx   = rr_idx;
                end
            end
        end
    end

    // Reset gates the read strobe directly so no FIFO is popped while held in reset.
    assign grant_en = grant_valid && rst;

    always_comb begin
        pop = '0;
        if (grant_en) begin
            pop[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= IDLE;
            ptr_reg         <= LN'(N-1);
            stage_valid_reg <= 1'b0;
            stage_data_reg  <= '0;
            stage_dest_reg  <= '0;
            for (int j = 0; j < N; j++) begin
                cnt_reg[j] <= '0;
            end
        end else begin
            state_reg       <= state_next;
            stage_valid_reg <= grant_en;
            if (grant_en) begin
                stage_data_reg <= data_poped[grant_idx*DW +: DW];
                stage_dest_reg <= dest[grant_idx];
                if (!modo) begin
                    ptr_reg <= grant_idx;
                end
            end
            if (stage_valid_reg) begin
                cnt_reg[stage_dest_reg] <= cnt_reg[stage_dest_reg] + 1'b1;
            end
        end
    end

    // The stage drains every cycle, so it is empty after this edge exactly when nothing is granted.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_en)  state_next = ACTIVE;
            ACTIVE:  if (!grant_en) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign idle = (state_reg == IDLE) && !stage_valid_reg && !grant_en;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_out
            assign push[gi]                = stage_valid_reg && (stage_dest_reg == LN'(gi));
            assign data_pushed[gi*DW +: DW] = push[gi] ? stage_data_reg : '0;
            assign cuenta[gi*CW +: CW]      = cnt_reg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_arbitro_param.sv
// Directed bench for arbitro_param (N=4, DW=10, CW=8): inputs driven 1ns after
// the rising edge, outputs sampled 2ns after it.
module tb_arbitro_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        modo;
    logic [3:0]  empty;
    logic [39:0] data_poped;
    logic [3:0]  alm_full;
    logic [3:0]  pop;
    logic [3:0]  push;
    logic [39:0] data_pushed;
    logic [31:0] cuenta;
    logic        idle;

    int vectors    = 0;
    int miscompares = 0;

    logic [3:0] rr_pop  [5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    int         rr_dst  [5] = '{0, 3, 2, 1, 0};
    logic [9:0] rr_word [5] = '{10'h000, 10'h310, 10'h221, 10'h132, 10'h043};

    always #5 clk = ~clk;

    arbitro_param #(.N(4), .DW(10), .CW(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .modo        (modo),
        .empty       (empty),
        .data_poped  (data_poped),
        .alm_full    (alm_full),
        .pop         (pop),
        .push        (push),
        .data_pushed (data_pushed),
        .cuenta      (cuenta),
        .idle        (idle)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("vector %0d %s: observed %0h expected %0h", vectors, tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_heads(input logic [9:0] w0, input logic [9:0] w1,
                             input logic [9:0] w2, input logic [9:0] w3);
        data_poped = {w3, w2, w1, w0};
    endtask

    function automatic logic [39:0] lane_word(input int j, input logic [9:0] w);
        return 40'(w) << (j*10);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; modo = 1'b0; empty = 4'hF; alm_full = 4'h0; data_poped = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state, with eligible inputs already present
        set_heads(10'h310, 10'h221, 10'h132, 10'h043);
        empty = 4'b0000;
        #1;
        chk("rst_pop",    pop,         4'h0);
        chk("rst_push",   push,        4'h0);
        chk("rst_data",   data_pushed, 40'h0);
        chk("rst_cuenta", cuenta,      32'h0);
        chk("rst_idle",   idle,        1'b1);

        // Round-robin, all inputs busy: pops 0,1,2,3,0 and pushes 3,2,1,0 one cycle later
        rst = 1'b1;
        #1;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) begin
                tick();
                #1;
            end
            chk("rr_pop",  pop,  rr_pop[c]);
            chk("rr_push", push, (c == 0) ? 4'h0 : 4'(1 << rr_dst[c]));
            chk("rr_data", data_pushed, (c == 0) ? 40'h0 : lane_word(rr_dst[c], rr_word[c]));
            chk("rr_idle", idle, 1'b0);
        end
        tick(); empty = 4'hF; #1;
        chk("rr_tail_pop",  pop,  4'h0);
        chk("rr_tail_push", push, 4'h8);
        chk("rr_tail_data", data_pushed, lane_word(3, 10'h310));
        chk("rr_tail_idle", idle, 1'b0);
        tick(); #1;
        chk("rr_done_push", push,   4'h0);
        chk("rr_done_idle", idle,   1'b1);
        chk("rr_cuenta",    cuenta, 32'h02010101);

        // Priority mode starves input 3; returning to round-robin grants 3 next
        tick(); empty = 4'b1101; #1;
        chk("pre_pop", pop, 4'h2);
        tick(); modo = 1'b1; empty = 4'b0101; #1;
        chk("prio_pop",  pop,  4'h2);
        chk("prio_push", push, 4'h4);
        repeat (2) begin
            tick(); #1;
            chk("prio_starve", pop, 4'h2);
        end
        tick(); modo = 1'b0; #1;
        chk("mode_back_pop", pop, 4'h8);
        tick(); empty = 4'hF; #1;
        chk("mode_back_push", push, 4'h1);
        chk("mode_back_data", data_pushed, lane_word(0, 10'h043));
        tick(); tick(); #1;
        chk("mode_idle",   idle,   1'b1);
        chk("mode_cuenta", cuenta, 32'h02050102);

        // Head-of-line stall on alm_full[2] does not block input 1
        tick();
        set_heads(10'h255, 10'h00F, 10'h132, 10'h043);
        alm_full = 4'b0100; empty = 4'b1100;
        #1;
        chk("hol_pop", pop, 4'h2);
        tick(); #1;
        chk("hol_again", pop, 4'h2);
        chk("hol_push",  push, 4'h1);
        chk("hol_data",  data_pushed, lane_word(0, 10'h00F));
        tick(); alm_full = 4'h0; #1;
        chk("hol_release", pop, 4'h1);
        tick(); empty = 4'hF; #1;
        chk("hol_rel_push", push, 4'h4);
        chk("hol_rel_data", data_pushed, lane_word(2, 10'h255));
        tick(); tick(); #1;
        chk("hol_cuenta", cuenta, 32'h02060104);

        // alm_full rising on the capture edge does not cancel the in-flight word
        tick(); set_heads(10'h2A5, 10'h00F, 10'h132, 10'h043); empty = 4'b1110; #1;
        chk("inflight_pop", pop, 4'h1);
        tick(); alm_full = 4'b0100; empty = 4'hF; #1;
        chk("inflight_push", push, 4'h4);
        chk("inflight_data", data_pushed, lane_word(2, 10'h2A5));
        chk("inflight_nopop", pop, 4'h0);
        tick(); alm_full = 4'h0; #1;
        chk("inflight_after", push, 4'h0);

        // Reset one cycle after a pop discards the captured word
        tick(); set_heads(10'h1AA, 10'h00F, 10'h1CC, 10'h043); empty = 4'b1110; #1;
        chk("rst2_pop", pop, 4'h1);
        tick(); rst = 1'b0; empty = 4'hF; #1;
        chk("rst2_push",   push,        4'h0);
        chk("rst2_data",   data_pushed, 40'h0);
        chk("rst2_cuenta", cuenta,      32'h0);
        chk("rst2_idle",   idle,        1'b1);
        tick(); #1;
        chk("rst2_hold_push", push, 4'h0);
        tick(); rst = 1'b1; #1;
        chk("rst2_rel_push",   push,   4'h0);
        chk("rst2_rel_cuenta", cuenta, 32'h0);
        chk("rst2_rel_idle",   idle,   1'b1);

        // 257 words to output 1: counter wraps through 0 to 1
        tick(); empty = 4'b1011; #1;
        chk("wrap_pop", pop, 4'h4);
        repeat (256) tick();
        #1;
        chk("wrap_255", cuenta, 32'h0000FF00);
        tick(); empty = 4'hF; #1;
        chk("wrap_0",    cuenta, 32'h00000000);
        chk("wrap_push", push,   4'h2);
        tick(); #1;
        chk("wrap_1",      cuenta, 32'h00000100);
        chk("wrap_idle",   idle,   1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/arbitro_param.md
ARBITRO_PARAM -- requirements
Module: arbitro_param

Interface
REQ-001 SHALL have parameter N, default 4, meaning channel count per side (power of two, 2..16).
REQ-002 SHALL have parameter DW, default 10, meaning word width, with destination field in bits [DW-1 -: log2(N)].
REQ-003 SHALL have parameter CW, default 8, meaning width of each per-output word counter.
REQ-004 SHALL have port clk, input, 1, meaning single clock, all state on rising edge.
REQ-005 SHALL have port rst, input, 1, meaning reset, asynchronous, active-low.
REQ-006 SHALL have port modo, input, 1, meaning 0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-007 SHALL have port empty, input, N, meaning per-input-FIFO empty flags.
REQ-008 SHALL have port data_poped, input, N*DW, meaning input-FIFO head words, first-word-fall-through, channel i at [i*DW +: DW].
REQ-009 SHALL have port alm_full, input, N, meaning per-output-FIFO almost-full flags, guaranteeing room for one in-flight word.
REQ-010 SHALL have port pop, output, N, meaning one-hot-or-zero input-FIFO read strobe.
REQ-011 SHALL have port push, output, N, meaning one-hot-or-zero output-FIFO write strobe.
REQ-012 SHALL have port data_pushed, output, N*DW, meaning routed word, valid only on the lane whose push is high.
REQ-013 SHALL have port cuenta, output, N*CW, meaning words pushed per output, lane j at [j*CW +: CW].
REQ-014 SHALL have port idle, output, 1, meaning high when the FSM is in IDLE and no word is in flight.

Function
REQ-015 SHALL compute dest(i) as the destination field of data_poped lane i.
REQ-016 SHALL deem input i eligible when empty[i]=0 and alm_full[dest(i)]=0.
REQ-017 SHALL derive pop combinationally in the same cycle, granting at most one eligible input per cycle.
REQ-018 SHALL, in round-robin mode, grant the first eligible input searching ptr+1, ptr+2, ... modulo N, where ptr is the last granted index.
REQ-019 SHALL, in priority mode, grant the lowest-index eligible input and leave ptr unchanged.
REQ-020 SHALL update ptr to the granted index on each round-robin grant.
REQ-021 SHALL sample modo each cycle, so a change affects the grant in that same cycle and ptr is preserved across mode changes.
REQ-022 SHALL, on a clock edge with pop[i]=1, capture data_poped lane i and dest(i) into a one-deep stage register.
REQ-023 SHALL assert push[dest] for exactly one cycle, with data_pushed lane dest equal to the captured word, giving a fixed latency of pop to push = 1 cycle.
REQ-024 SHALL drive push=0 and all data_pushed lanes to 0 in any cycle without a captured word.
REQ-025 SHALL sustain back-to-back grants at one word per cycle, with no bubble between consecutive pops.
REQ-026 SHALL stall an input blocked only by its destination's alm_full (head-of-line) without blocking other inputs.
REQ-027 SHALL not re-check alm_full when the in-flight word is pushed, so a word already popped is always pushed even if alm_full rises meanwhile.
REQ-028 SHALL increment cuenta[dest] by 1 on each push, wrapping from 2^CW-1 to 0 without saturation.
REQ-029 SHALL implement an FSM with states IDLE (no eligible input, stage empty) and ACTIVE (grant this cycle or word in stage).
REQ-030 SHALL transition IDLE->ACTIVE on any grant, ACTIVE->IDLE when there is no grant and the stage is empty after the push, and otherwise stay.

Reset
REQ-031 SHALL, while rst=0, force pop=0 asynchronously (combinational gate), push=0, data_pushed=0, cuenta=0, ptr=N-1, stage empty, state IDLE, and idle=1.
REQ-032 SHALL discard a word captured but not yet pushed when reset is asserted, so it is never pushed.
REQ-033 SHALL allow the first grant on the first rising edge after rst returns to 1, with round-robin starting at input 0.

Verification
REQ-034 SHALL cover: N=4, all inputs non-empty, heads destined 3,2,1,0, modo=0 -> pops 0,1,2,3,0 on consecutive cycles, pushes 3,2,1,0 one cycle later, idle=0 throughout.
REQ-035 SHALL cover: modo=1, inputs 1 and 3 non-empty -> pop[1] repeatedly and input 3 starved; then modo=0 -> the next grant is 3.
REQ-036 SHALL cover: alm_full[2]=1, input 0 head destined 2 and input 1 head destined 0 -> only input 1 is popped; deassert alm_full[2] -> input 0 is popped next eligible turn.
REQ-037 SHALL cover: word 10'h2A5 popped from input 0 with alm_full[2] rising the same edge -> push[2]=1 next cycle with data 10'h2A5.
REQ-038 SHALL cover: CW=8 with 257 words to output 1 -> cuenta lane 1 reads 1 after wrap.
REQ-039 SHALL cover: rst=0 one cycle after a pop -> no push occurs, cuenta stays 0, idle=1 immediately.
